// File: rtl/medidor_faixa_multi_uc.sv
// medidor_faixa_multi_uc: round-robin multi-sensor range-meter control unit with session window,
// per-measurement timeout and serial result message.
module medidor_faixa_multi_uc #(
  parameter int N_CANAIS     = 2,
  parameter int CHARS_MED    = 4,
  parameter int CHARS_ACERTO = 3,
  parameter int T_INTERVALO  = 25000000,
  parameter int T_JANELA     = 150000000,
  parameter int T_TIMEOUT    = 2500000,
  localparam int CMAX = (CHARS_MED > CHARS_ACERTO) ? CHARS_MED : CHARS_ACERTO,
  localparam int CW   = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1,
  localparam int IW   = (CMAX > 1) ? $clog2(CMAX) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          medir,
  input  logic          pronto_medida,
  input  logic          pronto_tx,
  output logic          mensurar,
  output logic [CW-1:0] canal,
  output logic [IW-1:0] indice_char,
  output logic          modo_acerto,
  output logic          partida_tx,
  output logic          registra_acertou,
  output logic          acertou,
  output logic          erro_medida,
  output logic [3:0]    db_estado
);
  localparam int JW  = (T_JANELA > 1) ? $clog2(T_JANELA) : 1;
  localparam int TW  = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;
  localparam int VW  = (T_INTERVALO > 1) ? $clog2(T_INTERVALO) : 1;
  typedef enum logic [3:0] {
    INICIAL         = 4'h0,
    PREPARACAO      = 4'h1,
    ENVIA_MENSURAR  = 4'h2,
    AGUARDA_MED     = 4'h3,
    ENVIA_PARTIDA   = 4'h4,
    AGUARDA_TX      = 4'h5,
    PROXIMO_CHAR    = 4'h6,
    PROXIMO_CANAL   = 4'h7,
    ESPERA          = 4'h8,
    PREPARA_ACERTO  = 4'h9,
    ENVIA_PARTIDA_A = 4'hA,
    AGUARDA_TX_A    = 4'hB,
    PROXIMO_CHAR_A  = 4'hC,
    ERRO_MED        = 4'hD,
    ACERTOU_PULSE   = 4'hF
  } estado_t;
  estado_t       estado;
  logic [JW-1:0] cnt_janela;
  logic [TW-1:0] cnt_tempo;
  logic [VW-1:0] cnt_intervalo;
  logic          fim_janela;
  logic          janela_ativa;
  // the window only counts while a sweep is running, never during the result message
  assign janela_ativa = estado inside {ENVIA_MENSURAR, AGUARDA_MED, ENVIA_PARTIDA, AGUARDA_TX,
                                       PROXIMO_CHAR, PROXIMO_CANAL, ESPERA, ERRO_MED};
  always_ff @(posedge clock) begin
    if (reset || !medir) begin
      estado        <= INICIAL;
      canal         <= '0;
      indice_char   <= '0;
      cnt_janela    <= '0;
      cnt_tempo     <= '0;
      cnt_intervalo <= '0;
      fim_janela    <= 1'b0;
    end else begin
      if (janela_ativa) begin
        if (cnt_janela == JW'(T_JANELA - 1)) fim_janela <= 1'b1;
        else cnt_janela <= cnt_janela + JW'(1);
      end
      case (estado)
        INICIAL: begin
          canal       <= '0;
          indice_char <= '0;
          estado      <= PREPARACAO;
        end
        PREPARACAO: begin
          cnt_janela  <= '0;
          fim_janela  <= 1'b0;
          canal       <= '0;
          indice_char <= '0;
          estado      <= ENVIA_MENSURAR;
        end
        ENVIA_MENSURAR: begin
          cnt_tempo   <= '0;
          indice_char <= '0;
          estado      <= AGUARDA_MED;
        end
        AGUARDA_MED: begin
          if (cnt_tempo != TW'(T_TIMEOUT - 1)) cnt_tempo <= cnt_tempo + TW'(1);
          if (fim_janela) estado <= PREPARA_ACERTO;
          else if (pronto_medida) estado <= ENVIA_PARTIDA;
          else if (cnt_tempo == TW'(T_TIMEOUT - 1)) estado <= ERRO_MED;
        end
        ENVIA_PARTIDA: estado <= AGUARDA_TX;
        AGUARDA_TX:
          if (pronto_tx) estado <= (indice_char < IW'(CHARS_MED - 1)) ? PROXIMO_CHAR : PROXIMO_CANAL;
        PROXIMO_CHAR: begin
          indice_char <= indice_char + IW'(1);
          estado      <= ENVIA_PARTIDA;
        end
        PROXIMO_CANAL: begin
          indice_char <= '0;
          if (fim_janela) estado <= PREPARA_ACERTO;
          else if (canal < CW'(N_CANAIS - 1)) begin
            canal  <= canal + CW'(1);
            estado <= ENVIA_MENSURAR;
          end else begin
            canal         <= '0;
            cnt_intervalo <= '0;
            estado        <= ESPERA;
          end
        end
        ESPERA: begin
          if (cnt_intervalo != VW'(T_INTERVALO - 1)) cnt_intervalo <= cnt_intervalo + VW'(1);
          if (fim_janela) estado <= PREPARA_ACERTO;
          else if (cnt_intervalo == VW'(T_INTERVALO - 1)) estado <= ENVIA_MENSURAR;
        end
        ERRO_MED: estado <= PROXIMO_CANAL;
        PREPARA_ACERTO: begin
          indice_char <= '0;
          estado      <= ENVIA_PARTIDA_A;
        end
        ENVIA_PARTIDA_A: estado <= AGUARDA_TX_A;
        AGUARDA_TX_A:
          if (pronto_tx) estado <= (indice_char < IW'(CHARS_ACERTO - 1)) ? PROXIMO_CHAR_A : ACERTOU_PULSE;
        PROXIMO_CHAR_A: begin
          indice_char <= indice_char + IW'(1);
          estado      <= ENVIA_PARTIDA_A;
        end
        ACERTOU_PULSE: begin
          canal       <= '0;
          indice_char <= '0;
          estado      <= INICIAL;
        end
        default: estado <= INICIAL;
      endcase
    end
  end
  assign mensurar         = estado == ENVIA_MENSURAR;
  assign partida_tx       = estado == ENVIA_PARTIDA || estado == ENVIA_PARTIDA_A;
  assign registra_acertou = estado == PREPARA_ACERTO;
  assign acertou          = estado == ACERTOU_PULSE;
  assign erro_medida      = estado == ERRO_MED;
  assign modo_acerto      = estado inside {PREPARA_ACERTO, ENVIA_PARTIDA_A, AGUARDA_TX_A,
                                           PROXIMO_CHAR_A, ACERTOU_PULSE};
  assign db_estado        = estado;
endmodule

// File: tb/tb_medidor_faixa_multi_uc.sv
// tb_medidor_faixa_multi_uc: directed table plus procedural session model for two window lengths.
module tb_medidor_faixa_multi_uc;
  logic       clock = 1'b0;
  logic       reset;
  logic       medir [2];
  logic       pm [2];
  logic       ptx [2];
  logic       mens [2];
  logic [1:0] can [2];
  logic [1:0] idx [2];
  logic       modo [2];
  logic       part [2];
  logic       rega [2];
  logic       acer [2];
  logic       erro [2];
  logic [3:0] est [2];
  int checks = 0, errors = 0;
  int sel, w, m_canal, m_idx, mode, mute, pm_d, tx_d;
  always #5 clock = ~clock;
  medidor_faixa_multi_uc #(.N_CANAIS(3), .CHARS_MED(2), .CHARS_ACERTO(3), .T_INTERVALO(8),
    .T_JANELA(400), .T_TIMEOUT(16)) dut_a (
    .clock(clock), .reset(reset), .medir(medir[0]), .pronto_medida(pm[0]), .pronto_tx(ptx[0]),
    .mensurar(mens[0]), .canal(can[0]), .indice_char(idx[0]), .modo_acerto(modo[0]),
    .partida_tx(part[0]), .registra_acertou(rega[0]), .acertou(acer[0]), .erro_medida(erro[0]),
    .db_estado(est[0]));
  medidor_faixa_multi_uc #(.N_CANAIS(3), .CHARS_MED(2), .CHARS_ACERTO(3), .T_INTERVALO(8),
    .T_JANELA(60), .T_TIMEOUT(16)) dut_b (
    .clock(clock), .reset(reset), .medir(medir[1]), .pronto_medida(pm[1]), .pronto_tx(ptx[1]),
    .mensurar(mens[1]), .canal(can[1]), .indice_char(idx[1]), .modo_acerto(modo[1]),
    .partida_tx(part[1]), .registra_acertou(rega[1]), .acertou(acer[1]), .erro_medida(erro[1]),
    .db_estado(est[1]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, sel, $time, act, exp);
    end
  endtask
  // expected outputs follow directly from the state meaning
  task automatic check_out(input int code, input int ch, input int ix);
    chk("db_estado", est[sel], code);
    chk("mensurar", mens[sel], code == 2);
    chk("partida_tx", part[sel], code == 4 || code == 10);
    chk("registra_acertou", rega[sel], code == 9);
    chk("acertou", acer[sel], code == 15);
    chk("erro_medida", erro[sel], code == 13);
    chk("modo_acerto", modo[sel], code inside {9, 10, 11, 12, 15});
    chk("canal", can[sel], ch);
    chk("indice_char", idx[sel], ix);
  endtask
  function automatic logic nz();
    return (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction
  function automatic int dly_med(input int c);
    if (mode == 2) return int'($urandom_range(0, 19));
    return (c == mute) ? 99 : pm_d;
  endfunction
  function automatic int dly_tx();
    return (mode == 2) ? int'($urandom_range(0, 4)) : tx_d;
  endfunction
  function automatic logic win_end();
    return w >= ((sel == 0) ? 400 : 60);
  endfunction
  task automatic cyc(input int code, input logic pmv, input logic ptxv);
    check_out(code, m_canal, m_idx);
    pm[sel] = pmv;
    ptx[sel] = ptxv;
    @(negedge clock);
    if (code inside {[2:8], 13}) w++;
  endtask
  task automatic send(input int n, input int st);
    int d;
    for (int k = 0; k < n; k++) begin
      m_idx = k;
      d = dly_tx();
      cyc(st, nz(), nz());
      for (int t = 0; t <= d; t++) cyc(st + 1, nz(), t == d);
      if (k < n - 1) cyc(st + 2, nz(), nz());
    end
  endtask
  task automatic acerto(input int drop);
    int d;
    m_idx = 0;
    cyc(9, nz(), nz());
    for (int k = 0; k < 3; k++) begin
      m_idx = k;
      cyc(10, nz(), nz());
      if (k == drop) begin
        medir[sel] = 1'b0;
        cyc(11, nz(), 1'b1);
        m_canal = 0;
        m_idx = 0;
        cyc(0, nz(), nz());
        return;
      end
      d = dly_tx();
      for (int t = 0; t <= d; t++) cyc(11, nz(), t == d);
      if (k < 2) cyc(12, nz(), nz());
    end
    m_idx = 2;
    cyc(15, nz(), nz());
    m_canal = 0;
    m_idx = 0;
  endtask
  task automatic session(input int drop);
    int t, d, res;
    logic f;
    w = 0;
    m_canal = 0;
    m_idx = 0;
    medir[sel] = 1'b1;
    cyc(0, nz(), nz());
    cyc(1, nz(), nz());
    forever begin
      for (int c = 0; c < 3; c++) begin
        m_canal = c;
        m_idx = 0;
        cyc(2, nz(), nz());
        d = dly_med(c);
        res = 0;
        t = 0;
        while (res == 0) begin
          if (win_end()) begin
            cyc(3, nz(), nz());
            acerto(drop);
            return;
          end
          cyc(3, t == d, nz());
          res = (t == d) ? 1 : (t == 15) ? 2 : 0;
          t++;
        end
        if (res == 1) begin
          send(2, 4);
          m_idx = 1;
        end else cyc(13, nz(), nz());
        f = win_end();
        cyc(7, nz(), nz());
        m_idx = 0;
        if (f) begin
          acerto(drop);
          return;
        end
      end
      m_canal = 0;
      for (t = 0; t < 8; t++) begin
        f = win_end();
        cyc(8, nz(), nz());
        if (f) begin
          acerto(drop);
          return;
        end
      end
    end
  endtask
  task automatic run(input int drop);
    session(drop);
    medir[sel] = 1'b0;
    cyc(0, 1'b0, 1'b0);
  endtask
  typedef struct packed {
    logic rst, md, pmv, ptxv;
    logic [3:0] st;
    logic [1:0] ch, ix;
  } vec_t;
  function automatic vec_t mk(input logic r, md, p, x, input int st, ch, ix);
    return {r, md, p, x, 4'(st), 2'(ch), 2'(ix)};
  endfunction
  initial begin
    vec_t tbl [17];
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 2, 0, 0);
    tbl[4]  = mk(0, 1, 0, 1, 3, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 4, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 5, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 6, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 4, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 5, 0, 1);
    tbl[10] = mk(0, 1, 0, 1, 7, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 2, 1, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, 0, 1, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 2, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      medir[i] = 1'b0;
      pm[i] = 1'b0;
      ptx[i] = 1'b0;
    end
    sel = 0; mode = 0; mute = -1; pm_d = 4; tx_d = 2;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst;
      medir[0] = tbl[i].md;
      pm[0] = tbl[i].pmv;
      ptx[0] = tbl[i].ptxv;
      @(negedge clock);
      check_out(tbl[i].st, tbl[i].ch, tbl[i].ix);
    end
    reset = 1'b0; pm[0] = 1'b0; ptx[0] = 1'b0;
    run(-1);
    mute = 1;
    run(-1);
    mute = -1; pm_d = 15;
    run(-1);
    sel = 1; pm_d = 2; tx_d = 2;
    run(-1);
    run(1);
    run(-1);
    mode = 2;
    for (int i = 0; i < 8; i++) begin
      int dr;
      sel = int'($urandom_range(0, 1));
      dr = int'($urandom_range(0, 5));
      run((dr > 2) ? -1 : dr);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
